// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pin and local byte-exchange signals between master side and slave
interface spi_slave_if;
    logic       select;
    logic       mclk;
    logic       mosi;
    logic       miso;
    logic [7:0] din;
    logic [7:0] dout;
    logic       request;
    modport master (output select, mclk, mosi, din, input miso, dout, request);
    modport slave  (input select, mclk, mosi, din, output miso, dout, request);
endinterface

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI mode 3 slave, MSB first, 8-bit frames, one-cycle request strobe
module spi_slave (
    input  logic        clk,
    input  logic        rst_n,
    spi_slave_if.slave  bus
);
    logic [2:0] sel_s, mclk_s;
    logic [1:0] mosi_s;
    logic [2:0] cnt;
    logic [7:0] rx, tx, dout;
    logic       request, load;
    logic       sel, sel_rise, rise, fall;
    always_comb begin
        sel      = sel_s[1];
        sel_rise = sel_s[1] & ~sel_s[2];
        rise     = sel & mclk_s[1] & ~mclk_s[2];
        fall     = sel & ~mclk_s[1] & mclk_s[2];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s   <= 3'b000;
            mclk_s  <= 3'b111;
            mosi_s  <= 2'b00;
            cnt     <= 3'd0;
            rx      <= 8'h00;
            tx      <= 8'h00;
            dout    <= 8'h00;
            request <= 1'b0;
            load    <= 1'b0;
        end else begin
            sel_s   <= {sel_s[1:0], bus.select};
            mclk_s  <= {mclk_s[1:0], bus.mclk};
            mosi_s  <= {mosi_s[0], bus.mosi};
            load    <= request;
            request <= sel_rise | (rise & (cnt == 3'd7));
            cnt     <= (!sel || sel_rise) ? 3'd0 : rise ? cnt + 3'd1 : cnt;
            if (rise)
                rx <= {rx[6:0], mosi_s[1]};
            if (rise && cnt == 3'd7)
                dout <= {rx[6:0], mosi_s[1]};
            // a fall with cnt==0 leaves the freshly loaded MSB on miso
            if (load)
                tx <= bus.din;
            else if (fall && cnt != 3'd0)
                tx <= {tx[6:0], 1'b0};
        end
    end
    assign bus.miso    = sel & tx[7];
    assign bus.dout    = dout;
    assign bus.request = request;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed SPI master stimulus with a request-driven scoreboard for spi_slave
module tb_spi_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    spi_slave_if bus ();
    spi_slave dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic       chk;
        logic [7:0] dout;
        logic [7:0] din;
    } ent_t;
    ent_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int ph = 6;
    logic [7:0] last_dout = 8'h00;
    logic [7:0] mo[8];
    logic [7:0] so[8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // drive nbits of m MSB first; master samples miso just before each rise
    task automatic send_byte(input logic [7:0] m, input logic [7:0] exp, input int nbits, input bit chk_miso);
        logic [7:0] got;
        got = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            bus.mclk = 1'b0;
            bus.mosi = m[i];
            cyc(ph);
            got[i] = bus.miso;
            bus.mclk = 1'b1;
            cyc(ph);
        end
        if (chk_miso) check("miso_byte", got, exp);
    endtask

    task automatic xfer(input int n);
        sb.push_back('{chk: 1'b0, dout: 8'h00, din: so[0]});
        bus.select = 1'b1;
        cyc(8);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{chk: 1'b1, dout: mo[i], din: (i + 1 < n) ? so[i + 1] : 8'h00});
            send_byte(mo[i], so[i], 8, 1'b1);
        end
        cyc(6);
        bus.select = 1'b0;
        cyc(8);
        last_dout = mo[n - 1];
        check("dout_after_xfer", bus.dout, last_dout);
    endtask

    // monitor: pops one entry per request, supplies din in the following cycle
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.request) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_request: got 1 expected 0 (dout=%h)", bus.dout);
                    e = '{chk: 1'b0, dout: 8'h00, din: 8'h00};
                end else begin
                    e = sb.pop_front();
                    if (e.chk) check("dout_at_request", bus.dout, e.dout);
                end
                @(posedge clk);
                #1 bus.din = e.din;
                @(negedge clk);
                check("request_width", {7'd0, bus.request}, 8'h00);
                @(posedge clk);
                #1 bus.din = 8'h5A;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bus.select = 1'b0;
        bus.mclk   = 1'b1;
        bus.mosi   = 1'b0;
        bus.din    = 8'h5A;
        cyc(3);
        check("reset_dout", bus.dout, 8'h00);
        check("reset_request", {7'd0, bus.request}, 8'h00);
        check("reset_miso", {7'd0, bus.miso}, 8'h00);
        rst_n = 1'b1;
        cyc(4);
        // deselected traffic must be ignored
        send_byte(8'hAB, 8'h00, 8, 1'b0);
        cyc(8);
        check("desel_dout", bus.dout, 8'h00);
        check("desel_miso", {7'd0, bus.miso}, 8'h00);
        // single byte
        so[0] = 8'h89; mo[0] = 8'hCD;
        xfer(1);
        // two bytes
        so[0] = 8'h12; so[1] = 8'h34; mo[0] = 8'h56; mo[1] = 8'h78;
        xfer(2);
        // partial byte then deselect, followed by a full byte
        sb.push_back('{chk: 1'b0, dout: 8'h00, din: 8'h77});
        bus.select = 1'b1;
        cyc(8);
        send_byte(8'hF0, 8'h00, 4, 1'b0);
        cyc(6);
        bus.select = 1'b0;
        cyc(8);
        check("partial_dout", bus.dout, last_dout);
        so[0] = 8'h3E; mo[0] = 8'hA5;
        xfer(1);
        // reset pulsed mid-byte
        sb.push_back('{chk: 1'b0, dout: 8'h00, din: 8'hE1});
        bus.select = 1'b1;
        cyc(8);
        send_byte(8'hC0, 8'h00, 4, 1'b0);
        rst_n = 1'b0;
        bus.select = 1'b0;
        bus.mclk = 1'b1;
        cyc(1);
        check("rst_dout", bus.dout, 8'h00);
        check("rst_miso", {7'd0, bus.miso}, 8'h00);
        check("rst_request", {7'd0, bus.request}, 8'h00);
        cyc(2);
        rst_n = 1'b1;
        last_dout = 8'h00;
        cyc(4);
        so[0] = 8'hC3; mo[0] = 8'h3C;
        xfer(1);
        // back-to-back at minimum phase
        ph = 4;
        so[0] = 8'hFF; so[1] = 8'h00; so[2] = 8'hFF; so[3] = 8'h00;
        mo[0] = 8'h00; mo[1] = 8'hFF; mo[2] = 8'h00; mo[3] = 8'hFF;
        xfer(4);
        so[0] = 8'h00; so[1] = 8'hFF; so[2] = 8'h81;
        mo[0] = 8'hFF; mo[1] = 8'h00; mo[2] = 8'h7E;
        xfer(3);
        cyc(10);
        check("missing_requests", 8'(sb.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
